// File: rtl/sca_psum_accumulator.sv
// Partial-sum accumulator for the SCA 4x4 conv path.
// Sums N_GROUPS three-channel tiles, then requantises and streams one channel tile per handshake.
module sca_psum_accumulator #(
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_GROUPS = 4,
    parameter int unsigned SHIFT    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [ACC_W-1:0]  u0_in [0:3][0:3],
    input  logic signed [ACC_W-1:0]  u1_in [0:3][0:3],
    input  logic signed [ACC_W-1:0]  u2_in [0:3][0:3],
    output logic                     in_ready,
    output logic                     overflow_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_ch,
    output logic signed [DATA_W-1:0] out_data [0:3][0:3],
    output logic                     out_last,
    output logic                     sat_flag
);

    // Headroom so N_GROUPS full-scale sums never wrap.
    localparam int unsigned AW = ACC_W + $clog2(N_GROUPS) + 1;
    localparam int unsigned GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(N_GROUPS - 1);

    // Requant constants, one bit wider than the accumulator so the rounding add cannot wrap.
    localparam logic signed [AW:0] RND   = ((AW+1)'(1) << SHIFT) >> 1;
    localparam logic signed [AW:0] MAX_V = {{(AW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW:0] MIN_V = {{(AW-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [0:0] {StAcc, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          grp_q;
    logic signed [AW-1:0]   acc_q [0:2][0:3][0:3];
    logic signed [AW-1:0]   acc_d [0:2][0:3][0:3];
    logic signed [ACC_W-1:0] u_all [0:2][0:3][0:3];
    logic signed [DATA_W-1:0] rq_data [0:3][0:3];
    logic                   rq_sat;
    logic [1:0]             src_ch;
    logic                   accept;
    logic                   last_grp;
    logic                   hs;
    logic                   drain_done;

    assign u_all[0] = u0_in;
    assign u_all[1] = u1_in;
    assign u_all[2] = u2_in;

    assign in_ready   = (state_q == StAcc);
    assign accept     = in_ready && valid_in;
    assign last_grp   = (grp_q == LAST_GRP);
    assign hs         = out_valid && out_ready;
    assign drain_done = (state_q == StDrain) && hs && (out_ch == 2'd2);

    // Round-half-up, arithmetic shift, clamp; bit DATA_W of the result is the clamp flag.
    function automatic logic [DATA_W:0] requant(input logic signed [AW-1:0] a);
        logic signed [AW:0] s;
        s = {a[AW-1], a} + RND;
        s = s >>> SHIFT;
        if (s > MAX_V) begin
            requant = {1'b1, MAX_V[DATA_W-1:0]};
        end else if (s < MIN_V) begin
            requant = {1'b1, MIN_V[DATA_W-1:0]};
        end else begin
            requant = {1'b0, s[DATA_W-1:0]};
        end
    endfunction

    // Next accumulator contents: group 0 overwrites, later groups add.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    acc_d[ch][r][c] = acc_q[ch][r][c];
                    if (accept) begin
                        if (grp_q == '0) begin
                            acc_d[ch][r][c] = AW'(u_all[ch][r][c]);
                        end else begin
                            acc_d[ch][r][c] = acc_q[ch][r][c] + AW'(u_all[ch][r][c]);
                        end
                    end
                end
            end
        end
    end

    // Requantise the channel about to be presented; ch0 comes straight from the final sum.
    always_comb begin
        src_ch = (out_ch == 2'd0) ? 2'd1 : 2'd2;
        rq_sat = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [DATA_W:0] q;
                if (state_q == StAcc) begin
                    q = requant(acc_d[0][r][c]);
                end else begin
                    q = requant(acc_q[src_ch][r][c]);
                end
                rq_data[r][c] = q[DATA_W-1:0];
                rq_sat        = rq_sat | q[DATA_W];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcc:   if (accept && last_grp) state_d = StDrain;
            StDrain: if (drain_done)         state_d = StAcc;
            default: state_d = StAcc;
        endcase
    end

    // State, group counter and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAcc;
            grp_q   <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        acc_q[ch][r][c] <= '0;
                    end
                end
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (accept) begin
                grp_q <= last_grp ? '0 : grp_q + 1'b1;
            end
        end
    end

    // Output stream registers and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
            out_valid    <= 1'b0;
            out_ch       <= 2'd0;
            out_last     <= 1'b0;
            sat_flag     <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    out_data[r][c] <= '0;
                end
            end
        end else begin
            if (valid_in && !in_ready) begin
                overflow_err <= 1'b1;
            end
            if (accept && last_grp) begin
                out_valid <= 1'b1;
                out_ch    <= 2'd0;
                out_last  <= 1'b0;
                out_data  <= rq_data;
                sat_flag  <= rq_sat;
            end else if (state_q == StDrain && hs) begin
                if (out_ch == 2'd2) begin
                    out_valid <= 1'b0;
                    out_ch    <= 2'd0;
                    out_last  <= 1'b0;
                    sat_flag  <= 1'b0;
                end else begin
                    out_ch   <= out_ch + 2'd1;
                    out_last <= (out_ch == 2'd1);
                    out_data <= rq_data;
                    sat_flag <= rq_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_sca_psum_accumulator.sv
// Directed self-checking bench for sca_psum_accumulator (N_GROUPS=4, SHIFT=8).
module tb_sca_psum_accumulator;

    logic                clk;
    logic                rst;
    logic                valid_in;
    logic signed [31:0]  u0_in [0:3][0:3];
    logic signed [31:0]  u1_in [0:3][0:3];
    logic signed [31:0]  u2_in [0:3][0:3];
    logic                in_ready;
    logic                overflow_err;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_ch;
    logic signed [15:0]  out_data [0:3][0:3];
    logic                out_last;
    logic                sat_flag;

    int checks   = 0;
    int failures = 0;

    sca_psum_accumulator #(
        .ACC_W    (32),
        .DATA_W   (16),
        .N_GROUPS (4),
        .SHIFT    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .u0_in        (u0_in),
        .u1_in        (u1_in),
        .u2_in        (u2_in),
        .in_ready     (in_ready),
        .overflow_err (overflow_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_data     (out_data),
        .out_last     (out_last),
        .sat_flag     (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One tile; element (r,c) of channel k is vk + (4r+c)*sk.
    task automatic send_tile(input logic signed [31:0] v0, input logic signed [31:0] s0,
                             input logic signed [31:0] v1, input logic signed [31:0] s1,
                             input logic signed [31:0] v2, input logic signed [31:0] s2);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                u0_in[r][c] = v0 + (r * 4 + c) * s0;
                u1_in[r][c] = v1 + (r * 4 + c) * s1;
                u2_in[r][c] = v2 + (r * 4 + c) * s2;
            end
        end
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic send_group(input logic signed [31:0] v0, input logic signed [31:0] s0,
                              input logic signed [31:0] v1, input logic signed [31:0] s1,
                              input logic signed [31:0] v2, input logic signed [31:0] s2);
        for (int g = 0; g < 4; g++) send_tile(v0, s0, v1, s1, v2, s2);
    endtask

    // Result must be presented on the first negedge after the last tile.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 0);
    endtask

    task automatic check_tile(input string tag, input int ch, input int base, input int step,
                              input logic exp_sat);
        check($sformatf("%s_ch%0d_valid", tag, ch), out_valid, 1);
        check($sformatf("%s_ch%0d_ch", tag, ch), out_ch, ch);
        check($sformatf("%s_ch%0d_last", tag, ch), out_last, (ch == 2) ? 1 : 0);
        check($sformatf("%s_ch%0d_sat", tag, ch), sat_flag, exp_sat);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_ch%0d_e%0d", tag, ch, r * 4 + c), out_data[r][c],
                      base + (r * 4 + c) * step);
            end
        end
    endtask

    // Checks ch0 and ch1, stops on the negedge that shows ch2.
    task automatic recv_group(input string tag,
                              input int b0, input int s0, input logic t0,
                              input int b1, input int s1, input logic t1,
                              input int b2, input int s2, input logic t2);
        wait_valid(tag);
        check_tile(tag, 0, b0, s0, t0);
        @(negedge clk);
        check_tile(tag, 1, b1, s1, t1);
        @(negedge clk);
        check_tile(tag, 2, b2, s2, t2);
    endtask

    task automatic done_check(input string tag);
        @(negedge clk);
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_done_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                u0_in[r][c] = '0;
                u1_in[r][c] = '0;
                u2_in[r][c] = '0;
            end
        end
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow", overflow_err, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_data00", out_data[0][0], 0);
        check("rst_data33", out_data[3][3], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic sum: 4*256>>8=4, 4*-256>>8=-4.
        send_group(256, 0, -256, 0, 0, 0);
        recv_group("basic", 4, 0, 0, -4, 0, 0, 0, 0, 0);
        done_check("basic");

        // Positive saturation; a tile during the ch2 handshake is dropped.
        send_group(32'h7FFF_0000, 0, 0, 0, 0, 0);
        recv_group("satpos", 32767, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) u0_in[r][c] = 5000;
        end
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("drop_hs_overflow", overflow_err, 1);
        check("drop_hs_ready", in_ready, 1);
        check("drop_hs_valid", out_valid, 0);
        // Negative saturation, starting one cycle after the previous handshake.
        send_group(32'h8000_0000, 0, 0, 0, 0, 0);
        recv_group("satneg", -32768, 0, 1, 0, 0, 0, 0, 0, 0);
        done_check("satneg");

        // Rounding: 127->0, 128->1, 384->2.
        send_tile(127, 0, 128, 0, 96, 0);
        send_tile(0, 0, 0, 0, 96, 0);
        send_tile(0, 0, 0, 0, 96, 0);
        send_tile(0, 0, 0, 0, 96, 0);
        recv_group("rnd_a", 0, 0, 0, 1, 0, 0, 2, 0, 0);
        done_check("rnd_a");
        // Rounding: -384->-1, -129->-1, -128->0.
        send_tile(-96, 0, -129, 0, -128, 0);
        send_tile(-96, 0, 0, 0, 0, 0);
        send_tile(-96, 0, 0, 0, 0, 0);
        send_tile(-96, 0, 0, 0, 0, 0);
        recv_group("rnd_b", -1, 0, 0, -1, 0, 0, 0, 0, 0);
        done_check("rnd_b");

        // Mid-operation reset discards two partial tiles and clears overflow.
        send_tile(1000, 0, 1000, 0, 1000, 0);
        send_tile(1000, 0, 1000, 0, 1000, 0);
        rst = 1'b1;
        #1;
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_overflow", overflow_err, 0);
        check("mrst_out_ch", out_ch, 0);
        @(negedge clk);
        rst = 1'b0;
        send_group(256, 0, 0, 0, 0, 0);
        recv_group("mrst", 4, 0, 0, 0, 0, 0, 0, 0, 0);
        done_check("mrst");

        // Consumer stall on ch1 with a stray tile arriving mid-stall.
        check("stall_pre_overflow", overflow_err, 0);
        send_group(256, 0, 512, 0, 0, 0);
        wait_valid("stall");
        check_tile("stall", 0, 4, 0, 0);
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_tile($sformatf("stall%0d", k), 1, 8, 0, 0);
            check($sformatf("stall%0d_in_ready", k), in_ready, 0);
            if (k == 1) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) u2_in[r][c] = 777;
                end
                valid_in = 1'b1;
            end
            @(negedge clk);
            valid_in = 1'b0;
        end
        check("stall_overflow", overflow_err, 1);
        out_ready = 1'b1;
        check_tile("stall_rel", 1, 8, 0, 0);
        @(negedge clk);
        check_tile("stall_rel", 2, 0, 0, 0);
        done_check("stall");
        send_group(256, 0, 0, 0, 0, 0);
        recv_group("post_stall", 4, 0, 0, 0, 0, 0, 0, 0, 0);
        done_check("post_stall");

        // Back-to-back groups with element-distinct data.
        send_group(0, 256, 0, -256, 0, 64);
        recv_group("b2b_a", 0, 4, 0, 0, -4, 0, 0, 1, 0);
        done_check("b2b_a");
        send_group(256, 0, -256, 0, 0, 0);
        recv_group("b2b_b", 4, 0, 0, -4, 0, 0, 0, 0, 0);
        done_check("b2b_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
